// File: rtl/alu_vector_gen_if.sv
// alu_vector_gen_if: stimulus/result bundle between the vector generator and the unit under test
interface alu_vector_gen_if #(parameter int ERR_W = 8);
  logic             start;
  logic [3:0]       dut_d;
  logic             dut_cout;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             s1;
  logic             s0;
  logic             cin;
  logic [4:0]       goodresult;
  logic [4:0]       myresult;
  logic             mismatch;
  logic [ERR_W-1:0] err_count;
  logic [10:0]      first_fail;
  logic             busy;
  logic             done;
  modport master (
    input  start, dut_d, dut_cout,
    output a, b, s1, s0, cin, goodresult, myresult, mismatch, err_count, first_fail, busy, done
  );
  modport slave (
    output start, dut_d, dut_cout,
    input  a, b, s1, s0, cin, goodresult, myresult, mismatch, err_count, first_fail, busy, done
  );
endinterface

// File: rtl/alu_vector_gen.sv
// alu_vector_gen: sweeps all 2048 add/sub/transfer vectors and scores the unit's settled result
module alu_vector_gen #(
  parameter int SETTLE = 8,
  parameter int ERR_W  = 8
) (
  input logic clk,
  input logic rst,
  alu_vector_gen_if.master bus
);
  localparam int WC_W = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  state_t          state, nxt;
  logic [10:0]     idx;
  logic [WC_W-1:0] wait_cnt;
  logic [3:0]      y;
  logic [4:0]      dut_res;
  logic            go, fail, last;
  // Operands come straight from the index register, so they hold steady through WAIT.
  assign bus.a      = idx[10:7];
  assign bus.s1     = idx[6];
  assign bus.s0     = idx[5];
  assign bus.b      = idx[4:1];
  assign bus.cin    = idx[0];
  assign y          = {bus.s1, bus.s0} == 2'b00 ? bus.b :
                      {bus.s1, bus.s0} == 2'b01 ? ~bus.b :
                      {bus.s1, bus.s0} == 2'b10 ? 4'h0 : 4'hf;
  assign bus.goodresult = {1'b0, bus.a} + {1'b0, y} + {4'b0, bus.cin};
  assign dut_res    = {bus.dut_cout, bus.dut_d};
  assign bus.busy   = state == WAIT || state == CHECK;
  assign bus.done   = state == DONE;
  always_comb begin
    go   = bus.start && (state == IDLE || state == DONE);
    fail = state == CHECK && dut_res != bus.goodresult;
    last = idx == 11'h7ff;
    nxt  = go ? WAIT :
           state == WAIT && wait_cnt == WC_W'(SETTLE - 1) ? CHECK :
           state == CHECK ? (last ? DONE : WAIT) : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      wait_cnt       <= '0;
      bus.myresult   <= '0;
      bus.mismatch   <= 1'b0;
      bus.err_count  <= '0;
      bus.first_fail <= '0;
    end else begin
      state        <= nxt;
      bus.mismatch <= fail;
      if (go) begin
        idx            <= '0;
        wait_cnt       <= '0;
        bus.err_count  <= '0;
        bus.first_fail <= '0;
      end
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (state == CHECK) begin
        bus.myresult <= dut_res;
        if (fail && ~&bus.err_count) bus.err_count <= bus.err_count + 1'b1;
        if (fail && bus.err_count == '0) bus.first_fail <= idx;
        if (!last) begin
          idx      <= idx + 1'b1;
          wait_cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_vector_gen.sv
// tb_alu_vector_gen: drives the generator against a behavioural unit model with injectable faults
module tb_alu_vector_gen;
  localparam int S  = 4;
  localparam int EW = 8;
  localparam int VL = S + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  alu_vector_gen_if #(.ERR_W(EW)) bus ();
  alu_vector_gen #(.SETTLE(S), .ERR_W(EW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  int mode = 0, fidx = 300;
  int npass = 0, ntot = 0;
  int cap [2048];
  int busy_cnt, mis_cnt, mis_cyc, first_idx, err_at_start, c0, len;
  logic [10:0] vidx;
  logic [4:0]  dres;
  typedef struct {int k; int exp;} vec_t;
  vec_t tbl [$];
  function automatic int golden(int k);
    int av = k / 128, s = (k / 32) % 4, bv = (k / 2) % 16, yv;
    yv = s == 0 ? bv : s == 1 ? 15 - bv : s == 2 ? 0 : 15;
    return av + yv + k % 2;
  endfunction
  function automatic int faulty(int k, int m, int f);
    int r = golden(k);
    if (m == 1) r = r - r % 2;
    if (m == 2 && k == f) r = r ^ 1;
    return r;
  endfunction
  assign vidx         = {bus.a, bus.s1, bus.s0, bus.b, bus.cin};
  assign dres         = 5'(faulty(int'(vidx), mode, fidx));
  assign bus.dut_d    = dres[3:0];
  assign bus.dut_cout = dres[4];
  always @(negedge clk) begin
    if (bus.busy) begin
      if (busy_cnt == 0) begin
        first_idx    = int'(vidx);
        err_at_start = int'(bus.err_count);
      end
      busy_cnt++;
      cap[vidx] = int'(bus.goodresult);
    end
    if (bus.mismatch) begin
      mis_cnt++;
      mis_cyc = cyc;
    end
  end
  task automatic chk(input string n, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask
  task automatic pulse_start();
    @(negedge clk);
    busy_cnt = 0; mis_cnt = 0; mis_cyc = -1; first_idx = -1; err_at_start = -1;
    foreach (cap[k]) cap[k] = -1;
    bus.start = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input bit noise, output int l);
    l = -1;
    for (int i = 0; i < 3 * 2048 * VL && l < 0; i++) begin
      if (bus.done) l = cyc - c0;
      else begin
        bus.start = noise && $urandom_range(0, 199) == 0;
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic verify(input string tag, input int l);
    int cnt = 0, first = -1, bad = 0;
    for (int k = 0; k < 2048; k++) begin
      if (faulty(k, mode, fidx) != golden(k)) begin
        if (cnt == 0) first = k;
        cnt++;
      end
      if (cap[k] != golden(k)) bad++;
    end
    chk({tag, " sweep_len"}, l, 2048 * VL);
    chk({tag, " busy_cycles"}, busy_cnt, 2048 * VL);
    chk({tag, " first_idx"}, first_idx, 0);
    chk({tag, " err_cleared"}, err_at_start, 0);
    chk({tag, " goodresult_bad"}, bad, 0);
    chk({tag, " err_count"}, int'(bus.err_count), cnt > 255 ? 255 : cnt);
    chk({tag, " mismatch_pulses"}, mis_cnt, cnt);
    if (cnt > 0) chk({tag, " first_fail"}, int'(bus.first_fail), first);
    chk({tag, " myresult"}, int'(bus.myresult), faulty(2047, mode, fidx));
    chk({tag, " done"}, int'(bus.done), 1);
  endtask
  function automatic int out_or();
    return int'(|{bus.a, bus.b, bus.s1, bus.s0, bus.cin, bus.goodresult, bus.myresult,
                  bus.mismatch, bus.err_count, bus.first_fail, bus.busy, bus.done});
  endfunction
  initial begin
    bus.start = 1'b0;
    tbl.push_back('{647, 5'b01001});
    tbl.push_back('{679, 5'b10010});
    tbl.push_back('{711, 5'b00110});
    tbl.push_back('{2017, 5'b11111});
    tbl.push_back('{0, 0});
    tbl.push_back('{1, 1});
    tbl.push_back('{30, 15});
    tbl.push_back('{2047, 31});
    #1 chk("reset_outputs", out_or(), 0);
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    pulse_start();
    wait_done(1'b1, len);
    verify("ideal", len);
    foreach (tbl[i]) chk($sformatf("vec idx%0d goodresult", tbl[i].k), cap[tbl[i].k], tbl[i].exp);
    mode = 1;
    pulse_start();
    wait_done(1'b0, len);
    verify("stuck_d0", len);
    mode = 2;
    fidx = 300;
    pulse_start();
    wait_done(1'b0, len);
    verify("fault300", len);
    chk("fault300 mismatch_cycle", mis_cyc, c0 + VL * 300 + VL);
    mode = 1;
    pulse_start();
    for (int i = 0; i < 1000 * VL && !(bus.busy && vidx == 11'd700); i++) @(negedge clk);
    chk("reach_idx700", int'(vidx), 700);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", out_or(), 0);
    @(negedge clk);
    rst = 1'b0;
    mode = 2;
    fidx = int'($urandom_range(0, 2047));
    pulse_start();
    wait_done(1'b0, len);
    verify("after_reset", len);
    chk("random_fault mismatch_cycle", mis_cyc, c0 + VL * fidx + VL);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
